// File: rtl/demux1to4_reg_pkg.sv
// -----------------------------------------------------------------------------
// demux1to4_reg_pkg
// Shared definitions for the registered 1-to-4 demultiplexer:
//   NUM_CH     - number of output channels
//   SEL_W      - width of the channel index
//   ch_state_e - per-channel holding-register state (EMPTY / FULL)
// -----------------------------------------------------------------------------
package demux1to4_reg_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/demux1to4_reg_slot.sv
// -----------------------------------------------------------------------------
// demux_ch_slot
// Single-entry output holding register with a load strobe on the write side
// and a valid/ready handshake on the read side.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (state -> EMPTY, data -> 0)
//   load_i   in   write data_i this cycle (only raised when the slot can take it)
//   data_i   in   WIDTH  word to store
//   ready_i  in   consumer takes the held word this cycle
//   valid_o  out  slot holds a word
//   data_o   out  WIDTH  held word (keeps last value after drain)
// -----------------------------------------------------------------------------
module demux_ch_slot
  import demux1to4_reg_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic. A load while FULL is only issued together with
  // ready_i, so the old word leaves as the new one arrives (no bubble).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      CH_EMPTY: begin
        if (load_i) begin
          state_d = CH_FULL;
          data_d  = data_i;
        end
      end
      CH_FULL: begin
        if (load_i) begin
          state_d = CH_FULL;
          data_d  = data_i;
        end else if (ready_i) begin
          state_d = CH_EMPTY;
        end
      end
      default: state_d = CH_EMPTY;
    endcase
  end

  // Outputs. Data is not cleared on drain; consumers qualify with valid_o.
  always_comb begin
    valid_o = (state_q == CH_FULL);
    data_o  = data_q;
  end

endmodule

// File: rtl/demux1to4_reg.sv
// -----------------------------------------------------------------------------
// demux1to4_reg
// Registered 1-to-4 demultiplexer: routes one input word per accept into one
// of four single-entry holding registers, each with its own valid/ready.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   d          in   WIDTH      input word
//   sel        in   2          destination channel (ignored with auto select)
//   in_valid   in   d/sel valid this cycle
//   in_ready   out  block accepts d this cycle (combinational, independent
//                   of in_valid)
//   y          out  4*WIDTH    channel k data on y[k*WIDTH +: WIDTH]
//   out_valid  out  4          bit k: channel k holds a word
//   out_ready  in   4          bit k: consumer k takes its word this cycle
//
// Build option:
//   DEMUX_AUTO_SEL_EN - target comes from an internal round-robin counter
//                       (0,1,2,3,0,...) advanced on each accept; sel ignored.
// -----------------------------------------------------------------------------
module demux1to4_reg
  import demux1to4_reg_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        d,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] y,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready
);

  logic [SEL_W-1:0]  tgt;
  logic              accept;
  logic [NUM_CH-1:0] load;

`ifdef DEMUX_AUTO_SEL_EN
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             unused_sel;

  assign unused_sel = ^sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Wraps 3 -> 0 naturally through the 2-bit width.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + SEL_W'(1);
    end
  end

  assign tgt = cnt_q;
`else
  assign tgt = sel;
`endif

  // Target can take a word if it is empty or is being drained this cycle.
  assign in_ready = !out_valid[tgt] | out_ready[tgt];
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign load[k] = accept & (tgt == SEL_W'(k));

    demux_ch_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[k]),
      .data_i  (d),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (y[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux1to4_reg.sv
module tb_demux1to4_reg;

  localparam int W  = 4;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  d;
  logic [1:0]    sel;
  logic          in_valid;
  logic          in_ready;
  logic [NC*W-1:0] y;
  logic [NC-1:0] out_valid;
  logic [NC-1:0] out_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one slot per channel, plus the round-robin pointer.
  bit       mv [NC];
  int       md [NC];
  int       mcnt;
  logic     ir_seen;

  always #5 clk = ~clk;

  demux1to4_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  function automatic int target(input int s);
`ifdef DEMUX_AUTO_SEL_EN
    return mcnt;
`else
    return s;
`endif
  endfunction

  function automatic logic [NC-1:0] model_valid();
    logic [NC-1:0] v;
    for (int k = 0; k < NC; k++) v[k] = mv[k];
    return v;
  endfunction

  function automatic logic [NC*W-1:0] model_y();
    logic [NC*W-1:0] v;
    for (int k = 0; k < NC; k++) v[k*W +: W] = W'(md[k]);
    return v;
  endfunction

  // One clock: drive, check in_ready before the edge, advance model, check state.
  task automatic step(input logic r, input logic iv, input int s, input int dd,
                      input logic [NC-1:0] ordy);
    int  t;
    bit  er;
    bit  acc;
    rst = r; in_valid = iv; sel = 2'(s); d = W'(dd); out_ready = ordy;
    #1;
    t  = target(s);
    er = !mv[t] || ordy[t];
    ir_seen = in_ready;
    check("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < NC; k++) begin mv[k] = 0; md[k] = 0; end
      mcnt = 0;
    end else begin
      acc = iv && er;
      for (int k = 0; k < NC; k++) begin
        if (acc && t == k) begin
          mv[k] = 1; md[k] = dd % (1 << W);
        end else if (ordy[k]) begin
          mv[k] = 0;
        end
      end
      if (acc) mcnt = (mcnt + 1) % NC;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(model_valid()));
    check("y", 32'(y), 32'(model_y()));
  endtask

  initial begin
    for (int k = 0; k < NC; k++) begin mv[k] = 0; md[k] = 0; end
    mcnt = 0;
    rst = 1'b1; in_valid = 1'b0; sel = '0; d = '0; out_ready = '0;

    // Reset state
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_y", 32'(y), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

`ifndef DEMUX_AUTO_SEL_EN
    // Routing sweep
    for (int s = 0; s < NC; s++) begin
      step(0, 1, s, 1, 4'b1111);
      check("route_ir", 32'(ir_seen), 32'h1);
      check("route_ov", 32'(out_valid), 32'(4'b0001 << s));
      check("route_y", 32'(y[s*W +: W]), 32'h1);
    end
    step(0, 0, 0, 0, 4'b1111);

    // Back-pressure on channel 2
    step(0, 1, 2, 1, 4'b0000);
    step(0, 1, 2, 0, 4'b0000);
    check("bp_ir_blocked", 32'(ir_seen), 32'h0);
    check("bp_y2_held", 32'(y[2*W +: W]), 32'h1);
    check("bp_ov_held", 32'(out_valid), 32'h4);
    step(0, 1, 2, 0, 4'b0100);
    check("bp_ir_pass", 32'(ir_seen), 32'h1);
    check("bp_y2_new", 32'(y[2*W +: W]), 32'h0);
    check("bp_ov_pass", 32'(out_valid), 32'h4);
    step(0, 0, 0, 0, 4'b1111);

    // Independence: channel 0 stalled, write channel 1
    step(0, 1, 0, 5, 4'b0000);
    step(0, 1, 1, 3, 4'b0000);
    check("ind_ir", 32'(ir_seen), 32'h1);
    check("ind_ov", 32'(out_valid), 32'h3);
    check("ind_y0", 32'(y[0 +: W]), 32'h5);
    check("ind_y1", 32'(y[W +: W]), 32'h3);

    // Simultaneous drain of all four
    step(0, 1, 2, 7, 4'b0000);
    step(0, 1, 3, 9, 4'b0000);
    check("drain_full", 32'(out_valid), 32'hf);
    step(0, 0, 0, 0, 4'b1111);
    check("drain_empty", 32'(out_valid), 32'h0);
    check("drain_y_kept", 32'(y[3*W +: W]), 32'h9);

    // Reset mid-operation with a pending write
    step(0, 1, 1, 4, 4'b0000);
    step(0, 1, 3, 6, 4'b0000);
    check("mid_ov", 32'(out_valid), 32'ha);
    step(1, 1, 0, 2, 4'b0000);
    check("mid_rst_ov", 32'(out_valid), 32'h0);
    check("mid_rst_y", 32'(y), 32'h0);
    check("mid_rst_ir", 32'(in_ready), 32'h1);
`else
    // Round-robin destinations with sel held at 0
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0, k + 1, 4'b1111);
      check("auto_ov", 32'(out_valid), 32'(4'b0001 << (k % NC)));
      check("auto_y", 32'(y[(k % NC)*W +: W]), 32'(k + 1));
    end
    step(1, 0, 0, 0, 4'b1111);
    step(0, 1, 0, 11, 4'b1111);
    check("auto_restart", 32'(out_valid), 32'h1);
    check("auto_restart_y", 32'(y[0 +: W]), 32'd11);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), int'($urandom_range(0, 3)),
           int'($urandom_range(0, (1 << W) - 1)), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux1to4_reg.md
Name: demux1to4_reg

Overview:
- Registered 1-to-4 demultiplexer. It is the receive-side counterpart of the team's 4:1 mux.
- Routes one input word, addressed by a 2-bit select, into one of four single-entry output holding registers.
- Each output has its own valid/ready handshake. The input side has valid/ready back-pressure.
- Sits downstream of the mux path so that multiplexed traffic can be fanned back out to four consumers.

Parameters:
- WIDTH, 1, data width of d and of each output channel.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- d  input  WIDTH  input data word.
- sel  input  2  destination channel index, 0..3.
- in_valid  input  1  d/sel are valid this cycle.
- in_ready  output  1  block accepts d this cycle.
- y  output  4*WIDTH  channel k data on y[k*WIDTH +: WIDTH].
- out_valid  output  4  bit k: channel k holds a word.
- out_ready  input  4  bit k: consumer k takes the word this cycle.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - out_valid = 4'b0000.
  - y = all zeros.
  - Select counter (optional feature only) = 0.
  - in_ready is combinational and reads 1 after reset.
- Per-channel state machine with two states, EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
  - EMPTY -> FULL: on accept with target k.
  - FULL -> EMPTY: out_ready[k]=1 and no accept to k.
  - FULL -> FULL with new data: out_ready[k]=1 and accept to k in the same cycle (pass-through, no bubble).
  - FULL with out_ready[k]=0: y[k] and out_valid[k] are held stable.
- in_ready = !out_valid[t] | out_ready[t], where t is the target channel. This is combinational, with no dependence on in_valid.
- Accept = in_valid & in_ready. On accept, d is registered into channel t.
- Latency: word accepted at edge N appears on y[t] with out_valid[t]=1 after edge N.
- Throughput: one word per cycle when consumers keep up.
- Non-target channels are unaffected by an accept. Their data and valid change only through their own out_ready.
- Simultaneous out_ready on several channels: each FULL channel with out_ready=1 drains independently in the same cycle.
- out_ready[k]=1 while channel k is EMPTY: no effect.
- in_valid=0: no state change except drains. sel and d are don't-care.
- Reset mid-operation: all held words are discarded, out_valid clears at the next edge, and no partial transfer completes.
- y is not cleared on drain. It holds the last word; consumers must qualify with out_valid.

Optional Feature:
- Macro DEMUX_AUTO_SEL_EN.
- Defined:
  - Target t comes from an internal 2-bit round-robin counter, not from sel. sel is ignored.
  - The counter increments by 1 on each accept and wraps 3 -> 0.
  - The counter resets to 0.
  - This inverts a scanning mux: consecutive words land on channels 0,1,2,3,0,...
- Undefined: t = sel, and no counter is implemented.

Decomposition:
- Shared package:
  - NUM_CH = 4.
  - SEL_W = 2.
  - Channel-state enum {CH_EMPTY, CH_FULL}.
- One natural sub-module, demux_ch_slot: a single-entry holding register with load/valid/ready, instantiated four times.
- The top level holds target decode, in_ready mux and the optional counter.

Test Plan:
- Routing, WIDTH=1:
  - After reset, out_ready=4'b1111, drive in_valid=1 and sweep sel 0..3 with d=1.
  - Required: the edge after each accept gives out_valid one-hot 0001, 0010, 0100, 1000 and y[sel]=1.
  - in_ready stays 1 throughout.
- Back-pressure:
  - out_ready=0; send d=1 on sel=2, then again on sel=2.
  - Required: in_ready=0 on the second attempt, y[2] and out_valid[2] held.
  - Raising out_ready[2] gives in_ready=1 and new data loads the same cycle.
- Independence:
  - Channel 0 FULL and stalled; send sel=1.
  - Required: accepted, out_valid=0011, channel 0 data unchanged.
- Simultaneous drain:
  - All four channels FULL; pulse out_ready=4'b1111 for one cycle with in_valid=0.
  - Required: out_valid=0000 next cycle.
- Reset mid-operation:
  - Channels 1 and 3 FULL; assert rst for one cycle.
  - Required: out_valid=0000, y=0, in_ready=1 after the edge.
- DEMUX_AUTO_SEL_EN defined:
  - Accept 6 words with sel held at 0 and out_ready=1111.
  - Required: destinations 0,1,2,3,0,1.
  - Reset then restarts at channel 0.
